sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock first-in/first-out buffer with registered read data and full/empty status flags. It decouples a producer and a consumer that share one clock, and it is the DUT driven through the `fifo_if` interface by the `test` program. Writes and reads are independent per-cycle strobes, each qualified internally by the status flags.

## Interface

Parameters:

- `DATA_WIDTH`, default 8: width of `wdata` and `rdata`.
- `DEPTH`, default 16: number of entries. Must be a power of two and at least 2.

Ports:

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-low. Asserting it (0) clears all state immediately. Release is synchronous to `clk`.
- `wr_en`  input  1: write request for the current cycle.
- `wdata`  input  `DATA_WIDTH`: write data, sampled when a write is accepted.
- `rd_en`  input  1: read request for the current cycle.
- `rdata`  output  `DATA_WIDTH`: registered read data.
- `full`  output  1: high when the FIFO holds `DEPTH` entries.
- `empty`  output  1: high when the FIFO holds 0 entries.
- `count`  output  `$clog2(DEPTH)+1`: number of stored entries. Present only when `SYNC_FIFO_COUNT_EN` is defined.

## Operation

- Storage is a `DEPTH`-entry array, addressed by write and read pointers of `$clog2(DEPTH)+1` bits. The extra MSB is the wrap bit.
- Write acceptance: `wr_en && !full`. An accepted write stores `wdata` at `wptr[low bits]` and increments `wptr`.
- Read acceptance: `rd_en && !empty`. An accepted read loads `mem[rptr[low bits]]` into `rdata` and increments `rptr`.
- Ignored requests:
  - A write while full is dropped. Memory and pointers are unchanged.
  - A read while empty is ignored. `rdata` holds its previous value.
- Simultaneous `wr_en` and `rd_en`:
  - Each is qualified independently against the flags at the start of the cycle.
  - When full, only the read is performed.
  - When empty, only the write is performed. There is no fall-through: the written word is readable starting next cycle.
  - Otherwise both are performed and occupancy is unchanged.
- Flags are combinational from the registered pointers:
  - `empty = (wptr == rptr)`.
  - `full = (wptr[MSB] != rptr[MSB]) && (wptr[low] == rptr[low])`.
- Pointers wrap naturally modulo `2*DEPTH`. Address bits wrap modulo `DEPTH`.
- `rdata` changes only on an accepted read.

## Timing

- Values after reset: `wptr = 0`, `rptr = 0`, `rdata = 0`, `empty = 1`, `full = 0`, `count = 0`. Memory contents are not reset.
- Write latency: data written at edge N can be read starting at edge N+1. `empty` falls right after edge N.
- Read latency: 1 cycle. `rdata` is valid right after the edge where the read was accepted.
- Flag updates: `full` and `empty` reflect pointer updates in the same cycle as the accepting edge, with no extra delay.
- Reset asserted mid-operation: the FIFO returns immediately to its reset values. All stored data is logically discarded.

## Configuration

- `SYNC_FIFO_COUNT_EN` defined: the `count` output exists and equals `wptr - rptr`. It is combinational and ranges 0 to `DEPTH`.
- `SYNC_FIFO_COUNT_EN` not defined: there is no `count` port and no subtractor. All other behaviour is identical.

## Structure

- Package `sync_fifo_pkg`:
  - Default constants `DATA_WIDTH_DEF = 8` and `DEPTH_DEF = 16`.
  - A function `ptr_w(depth)` returning `$clog2(depth)+1`.
- Sub-module `sync_fifo_mem`: simple dual-port register array with a synchronous write port and a synchronous registered read port. The top level holds the pointers, flags and qualification logic.

## Test plan

- Reset: drive `rst=0` for 5 cycles, then release. Required: `empty=1`, `full=0`, `rdata=0`.
- Fill: 16 back-to-back writes of `0x00` to `0x0F`. Required: `full=1` after the 16th edge. A 17th write of `0xAA` is dropped.
- Drain: 16 reads after the fill. Required: `rdata` sequence `0x00` to `0x0F`, each valid one cycle after its read request. `empty=1` after the 16th read. A 17th read leaves `rdata=0x0F`.
- Simultaneous access at half occupancy:
  - Setup: 8 entries stored.
  - Stimulus: `wr_en=rd_en=1` for 20 cycles.
  - Required: occupancy stays 8, data stays in order, and the pointers wrap correctly.
- Simultaneous access at the boundaries:
  - When full, both requests give a read only: `full` drops and nothing is written.
  - When empty, both requests give a write only: `empty` drops and `rdata` is unchanged.
- Reset mid-traffic: assert `rst=0` asynchronously between edges while 5 entries are stored. Required: `empty=1` and `rdata=0` immediately. With `SYNC_FIFO_COUNT_EN`, `count=0`.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the sync_fifo slice.
package sync_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 16;

  // Address bits plus one wrap bit that separates full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Array contents are not reset; only the read register clears.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AddrW     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [AddrW-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AddrW-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Define SYNC_FIFO_COUNT_EN to add the combinational occupancy output `count`.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = ptr_w(DEPTH);

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic            w_wr_acc;
  logic            w_rd_acc;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                 (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);

  // Both strobes are qualified against the flags seen before this edge.
  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
    end
  end

`ifdef SYNC_FIFO_COUNT_EN
  assign count = r_wptr - r_rptr;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[AddrW-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[AddrW-1:0]),
    .o_rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes expected read data, a monitor pops and compares.
module tb_sync_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0]    count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];     // model of stored entries
  logic [DW-1:0] exp_q[$];  // expected read data, in order
  logic [DW-1:0] m_rdata;   // model of held rdata

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .wdata (wdata),
    .rd_en (rd_en),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(mq.size() == DP));
    chk({tag, " rdata"}, 32'(rdata), 32'(m_rdata));
`ifdef SYNC_FIFO_COUNT_EN
    chk({tag, " count"}, 32'(count), 32'(mq.size()));
`endif
  endtask

  // One clock: drive at negedge, model the accepting edge, release strobes after it.
  task automatic cyc(input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit acc_w, acc_r;
    @(negedge clk);
    wr_en = wr;
    wdata = wd;
    rd_en = rd;
    acc_r = rd && (mq.size() > 0);
    acc_w = wr && (mq.size() < DP);
    if (acc_r) begin
      m_rdata = mq.pop_front();
      exp_q.push_back(m_rdata);
    end
    if (acc_w) mq.push_back(wd);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Monitor: a read is presented whenever rd_en meets a non-empty FIFO at the edge.
  initial begin : monitor
    bit fire;
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      fire = rd_en && !empty && rst;
      #2;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 0x%0h expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", 32'(rdata), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wdata   = '0;
    m_rdata = '0;
    rst     = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_state("in_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_state("after_reset");

    // Fill, then one write that must be dropped.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0);
      if (i == 14 || i == 15) chk_state("fill");
    end
    cyc(1'b1, 8'hAA, 1'b0);
    chk_state("write_when_full");

    // Drain; extra read must leave rdata at 0x0F.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1);
      if (i == 0 || i == 15) chk_state("drain");
    end
    cyc(1'b0, '0, 1'b1);
    chk_state("read_when_empty");
    chk("rdata_hold_0f", 32'(rdata), 32'h0F);

    // Half occupancy with simultaneous traffic across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, DW'(8'h40 + i), 1'b1);
      chk_state("simul_half");
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
    chk_state("half_drained");

    // Full boundary: both strobes give a read only.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0);
    chk_state("refill");
    cyc(1'b1, 8'hEE, 1'b1);
    chk_state("simul_full");
    chk("simul_full_rdata", 32'(rdata), 32'h60);
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
    chk_state("full_boundary_drained");

    // Empty boundary: both strobes give a write only, rdata held.
    cyc(1'b1, 8'h77, 1'b1);
    chk_state("simul_empty");
    chk("simul_empty_rdata", 32'(rdata), 32'h6F);
    cyc(1'b0, '0, 1'b1);
    chk("read_after_empty_write", 32'(rdata), 32'h77);

    // Asynchronous reset between edges with 5 entries stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h90 + i), 1'b0);
    chk_state("pre_reset");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    mq.delete();
    m_rdata = '0;
    chk_state("async_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1);
    chk_state("post_reset_read");

    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
